// File: rtl/dram_refresh_model.sv
// Behavioural DRAM array: rows decay after RETAIN idle cycles unless restored by a
// write, a read hit or a periodic refresh sweep that competes with host requests.
module dram_refresh_model #(
  parameter int DATA_W  = 4,
  parameter int ADDR_W  = 3,
  parameter int RETAIN  = 60,
  parameter int REF_INT = 40
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              ref_en,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              ref_busy
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int AGE_W = $clog2(RETAIN + 1);
  localparam int TMR_W = $clog2(REF_INT);
  localparam logic [AGE_W-1:0]  AGE_LAST = AGE_W'(RETAIN - 1);
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(REF_INT - 1);
  localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(DEPTH - 1);

  // state   | meaning
  // IDLE    | accepting requests unless a refresh is pending
  // ACT     | row-open cycle for the latched request
  // RW      | array access; a read registers its response here
  // REFRESH | sweep restoring one live row per cycle
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ACT     = 2'd1;
  localparam logic [1:0] RW      = 2'd2;
  localparam logic [1:0] REFRESH = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] sweep_q, sweep_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [AGE_W-1:0]  age_q [DEPTH];
  logic [AGE_W-1:0]  age_d [DEPTH];
  logic [DEPTH-1:0]  live_q, live_d;
  logic [DEPTH-1:0]  wr_row, rs_row;

  assign req_ready = rst_n && (state_q == IDLE) && !pend_q;
  assign ref_busy  = (state_q == REFRESH);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  // A write or restore on the same edge as decay takes precedence over the decay.
  always_comb begin : row_update
    wr_row = '0;
    rs_row = '0;
    if (state_q == RW) begin
      if (we_q) wr_row[addr_q] = 1'b1;
      else      rs_row[addr_q] = live_q[addr_q];
    end
    if (state_q == REFRESH) rs_row[sweep_q] = live_q[sweep_q];

    live_d = live_q;
    data_d = data_q;
    age_d  = age_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_row[i]) begin
        data_d[i] = wdata_q;
        live_d[i] = 1'b1;
        age_d[i]  = '0;
      end else if (rs_row[i]) begin
        age_d[i] = '0;
      end else if (live_q[i]) begin
        if (age_q[i] == AGE_LAST) begin
          live_d[i] = 1'b0;
          age_d[i]  = '0;
          data_d[i] = '0;
        end else begin
          age_d[i] = age_q[i] + AGE_W'(1);
        end
      end
    end
  end

  always_comb begin : ctrl
    state_d     = state_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    timer_d     = timer_q;
    pend_d      = pend_q;
    sweep_d     = sweep_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;

    if (ref_en) begin
      if (timer_q == TMR_LAST) begin
        timer_d = '0;
        pend_d  = 1'b1;
      end else begin
        timer_d = timer_q + TMR_W'(1);
      end
    end

    case (state_q)
      IDLE: begin
        if (pend_q) begin
          state_d = REFRESH;
          sweep_d = '0;
        end else if (req_valid) begin
          state_d = ACT;
          addr_d  = req_addr;
          we_d    = req_we;
          wdata_d = req_wdata;
        end
      end
      ACT: state_d = RW;
      RW: begin
        state_d = IDLE;
        if (!we_q) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = !live_q[addr_q];
          rsp_rdata_d = live_q[addr_q] ? data_q[addr_q] : '0;
        end
      end
      REFRESH: begin
        sweep_d = sweep_q + ADDR_W'(1);
        if (sweep_q == ROW_LAST) begin
          state_d = IDLE;
          pend_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      timer_q     <= '0;
      pend_q      <= 1'b0;
      sweep_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      live_q      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        age_q[i]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      timer_q     <= timer_d;
      pend_q      <= pend_d;
      sweep_q     <= sweep_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      live_q      <= live_d;
      data_q      <= data_d;
      age_q       <= age_d;
    end
  end

endmodule

// File: tb/tb_dram_refresh_model.sv
// Bench for dram_refresh_model: directed vector table, corner-case sequences and a
// randomized run against a retention-time reference model.
module tb_dram_refresh_model;
  timeunit 1ns;
  timeprecision 1ps;

  localparam int DATA_W  = 4;
  localparam int ADDR_W  = 3;
  localparam int RETAIN  = 60;
  localparam int REF_INT = 40;
  localparam int DEPTH   = 8;
  localparam int NV      = 17;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_we = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              ref_en = 1'b0;
  logic              req_ready, rsp_valid, rsp_err, ref_busy;
  logic [DATA_W-1:0] rsp_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dram_refresh_model #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RETAIN(RETAIN), .REF_INT(REF_INT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .ref_en(ref_en),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ref_busy(ref_busy)
  );

  typedef struct {
    logic       we;
    logic [2:0] addr;
    logic [3:0] wdata;
    int         gap;
    logic [3:0] exp_rdata;
    logic       exp_err;
  } vec_t;

  // Reference model: a row is live while it was written and no more than RETAIN
  // edges have passed since its last restore (write, read hit or refresh visit).
  int         m_e, m_mode, m_left, m_sweep, m_timer;
  bit         m_pend, m_acc;
  logic       m_we;
  logic [2:0] m_addr;
  logic [3:0] m_wd;
  logic [3:0] m_data [DEPTH];
  bit         m_written [DEPTH];
  int         m_last [DEPTH];
  logic       e_rsp_valid, e_err;
  logic [3:0] e_rdata;

  task automatic chk(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = 1'b0;
    tick(2);
    chk("reset_ready", int'(req_ready), 0);
    chk("reset_rsp_valid", int'(rsp_valid), 0);
    chk("reset_rsp_rdata", int'(rsp_rdata), 0);
    chk("reset_rsp_err", int'(rsp_err), 0);
    chk("reset_ref_busy", int'(ref_busy), 0);
    rst_n = 1'b1;
    #1;
    chk("post_reset_ready", int'(req_ready), 1);
    tick(1);
  endtask

  task automatic do_req(input logic we, input logic [2:0] a, input logic [3:0] d,
                        output logic [3:0] rd, output logic er, output int lat, output int nr);
    int n;
    n = 0;
    while (!req_ready && n < 50) begin
      tick(1);
      n++;
    end
    chk("req_ready_wait", int'(req_ready), 1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    tick(1);
    req_valid = 1'b0;
    rd = '0; er = 1'b0; lat = 0; nr = 0;
    for (int k = 1; k <= 6; k++) begin
      tick(1);
      if (rsp_valid) begin
        nr++;
        if (nr == 1) begin
          lat = k;
          rd  = rsp_rdata;
          er  = rsp_err;
        end
      end
    end
  endtask

  function automatic bit m_live(int r, int e);
    return m_written[r] && (e - m_last[r] <= RETAIN);
  endfunction

  function automatic void model_edge();
    bit wrap;
    m_e++;
    m_acc = 1'b0;
    e_rsp_valid = 1'b0;
    e_rdata = '0;
    e_err = 1'b0;
    if (!rst_n) begin
      m_mode = 0; m_left = 0; m_sweep = 0; m_timer = 0; m_pend = 1'b0;
      for (int r = 0; r < DEPTH; r++) begin
        m_written[r] = 1'b0;
        m_data[r] = '0;
        m_last[r] = 0;
      end
      return;
    end
    wrap = ref_en && (m_timer == REF_INT - 1);
    if (ref_en) m_timer = wrap ? 0 : m_timer + 1;
    case (m_mode)
      0: begin
        if (m_pend) begin
          m_mode = 2;
          m_sweep = 0;
        end else if (req_valid) begin
          m_mode = 1; m_left = 2; m_acc = 1'b1;
          m_we = req_we; m_addr = req_addr; m_wd = req_wdata;
        end
      end
      1: begin
        m_left--;
        if (m_left == 0) begin
          if (m_we) begin
            m_data[m_addr] = m_wd;
            m_written[m_addr] = 1'b1;
            m_last[m_addr] = m_e;
          end else begin
            e_rsp_valid = 1'b1;
            if (m_live(int'(m_addr), m_e)) begin
              e_rdata = m_data[m_addr];
              m_last[m_addr] = m_e;
            end else begin
              e_err = 1'b1;
            end
          end
          m_mode = 0;
        end
      end
      default: begin
        if (m_live(m_sweep, m_e)) m_last[m_sweep] = m_e;
        m_sweep++;
        if (m_sweep == DEPTH) begin
          m_mode = 0;
          m_pend = 1'b0;
          wrap = 1'b0;
        end
      end
    endcase
    if (wrap) m_pend = 1'b1;
  endfunction

  initial begin
    #(1_000_000);
    $display("FAIL watchdog: got no finish, expected finish before 1 ms");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vt [NV];
    logic [3:0] rd;
    logic       er;
    int         lat, nr, busy, pulses, bad, run, k;

    // gap = idle cycles before the op; a read after a write with gap g lands 7+g edges later
    vt[0]  = '{1'b1, 3'd3, 4'hA, 0,  4'h0, 1'b0};
    vt[1]  = '{1'b0, 3'd3, 4'h0, 0,  4'hA, 1'b0};
    vt[2]  = '{1'b0, 3'd0, 4'h0, 0,  4'h0, 1'b1};
    vt[3]  = '{1'b1, 3'd7, 4'hF, 0,  4'h0, 1'b0};
    vt[4]  = '{1'b0, 3'd7, 4'h0, 2,  4'hF, 1'b0};
    vt[5]  = '{1'b1, 3'd3, 4'h5, 0,  4'h0, 1'b0};
    vt[6]  = '{1'b0, 3'd3, 4'h0, 0,  4'h5, 1'b0};
    vt[7]  = '{1'b1, 3'd4, 4'hC, 0,  4'h0, 1'b0};
    vt[8]  = '{1'b0, 3'd4, 4'h0, 53, 4'hC, 1'b0};
    vt[9]  = '{1'b0, 3'd4, 4'h0, 53, 4'hC, 1'b0};
    vt[10] = '{1'b1, 3'd6, 4'h3, 0,  4'h0, 1'b0};
    vt[11] = '{1'b0, 3'd6, 4'h0, 54, 4'h0, 1'b1};
    vt[12] = '{1'b1, 3'd5, 4'h6, 0,  4'h0, 1'b0};
    vt[13] = '{1'b0, 3'd5, 4'h0, 60, 4'h0, 1'b1};
    vt[14] = '{1'b1, 3'd1, 4'h9, 0,  4'h0, 1'b0};
    vt[15] = '{1'b0, 3'd1, 4'h0, 45, 4'h9, 1'b0};
    vt[16] = '{1'b0, 3'd1, 4'h0, 45, 4'h9, 1'b0};

    ref_en = 1'b0;
    do_reset();
    for (int i = 0; i < NV; i++) begin
      tick(vt[i].gap);
      do_req(vt[i].we, vt[i].addr, vt[i].wdata, rd, er, lat, nr);
      if (vt[i].we) begin
        chk($sformatf("vec%0d_wr_no_rsp", i), nr, 0);
      end else begin
        chk($sformatf("vec%0d_rd_count", i), nr, 1);
        chk($sformatf("vec%0d_rd_latency", i), lat, 2);
        chk($sformatf("vec%0d_rd_data", i), int'(rd), int'(vt[i].exp_rdata));
        chk($sformatf("vec%0d_rd_err", i), int'(er), int'(vt[i].exp_err));
      end
    end

    // Reset during ACT of a write abandons it
    do_reset();
    req_valid = 1'b1; req_we = 1'b1; req_addr = 3'd2; req_wdata = 4'hE;
    tick(1);
    req_valid = 1'b0;
    rst_n = 1'b0;
    tick(1);
    chk("midrst_rsp_valid", int'(rsp_valid), 0);
    rst_n = 1'b1;
    nr = 0;
    for (int j = 0; j < 3; j++) begin
      tick(1);
      if (rsp_valid) nr++;
    end
    chk("midrst_no_rsp", nr, 0);
    do_req(1'b0, 3'd2, 4'h0, rd, er, lat, nr);
    chk("midrst_rd_count", nr, 1);
    chk("midrst_rd_data", int'(rd), 0);
    chk("midrst_rd_err", int'(er), 1);

    // Refresh pending beats a request that is already waiting
    do_reset();
    do_req(1'b1, 3'd3, 4'hB, rd, er, lat, nr);
    ref_en = 1'b1;
    tick(REF_INT);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 3'd3;
    chk("prio_ready_blocked", int'(req_ready), 0);
    busy = 0;
    k = 0;
    while (!req_ready && k < 40) begin
      tick(1);
      if (ref_busy) busy++;
      k++;
    end
    chk("prio_ready_after", int'(req_ready), 1);
    chk("prio_busy_len", busy, DEPTH);
    tick(1);
    req_valid = 1'b0;
    nr = 0; lat = 0; rd = '0; er = 1'b1;
    for (int j = 1; j <= 6; j++) begin
      tick(1);
      if (rsp_valid) begin
        nr++;
        if (nr == 1) begin
          lat = j; rd = rsp_rdata; er = rsp_err;
        end
      end
    end
    chk("prio_rsp_count", nr, 1);
    chk("prio_rsp_latency", lat, 2);
    chk("prio_rsp_data", int'(rd), 11);
    chk("prio_rsp_err", int'(er), 0);

    // Refresh keeps all rows alive across a long idle stretch
    do_reset();
    ref_en = 1'b1;
    for (int i = 0; i < DEPTH; i++) do_req(1'b1, 3'(i), 4'(i * 5 + 2), rd, er, lat, nr);
    pulses = 0; bad = 0; run = 0;
    repeat (300) begin
      tick(1);
      if (ref_busy) run++;
      else if (run != 0) begin
        pulses++;
        if (run != DEPTH) bad++;
        run = 0;
      end
    end
    chk("ret_pulses_ge6", int'(pulses >= 6), 1);
    chk("ret_pulse_len_errs", bad, 0);
    for (int i = 0; i < DEPTH; i++) begin
      do_req(1'b0, 3'(i), 4'h0, rd, er, lat, nr);
      chk($sformatf("ret_row%0d_data", i), int'(rd), (i * 5 + 2) % 16);
      chk($sformatf("ret_row%0d_err", i), int'(er), 0);
    end

    // Randomized run against the reference model
    m_e = 0;
    rst_n = 1'b0;
    req_valid = 1'b0;
    ref_en = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      model_edge();
      #1;
      chk("rnd_ready", int'(req_ready), int'(rst_n && m_mode == 0 && !m_pend));
      chk("rnd_ref_busy", int'(ref_busy), int'(m_mode == 2));
      chk("rnd_rsp_valid", int'(rsp_valid), int'(e_rsp_valid));
      if (e_rsp_valid) begin
        chk("rnd_rsp_rdata", int'(rsp_rdata), int'(e_rdata));
        chk("rnd_rsp_err", int'(rsp_err), int'(e_err));
      end
      if (m_acc || !req_valid) begin
        req_valid = ($urandom_range(0, 2) == 0);
        req_we    = 1'($urandom);
        req_addr  = 3'($urandom_range(0, 7));
        req_wdata = 4'($urandom);
      end
      if ($urandom_range(0, 149) == 0) ref_en = ~ref_en;
      rst_n = (c >= 1) && ($urandom_range(0, 799) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dram_refresh_model.md
DRAM_REFRESH_MODEL -- requirements
Module: dram_refresh_model

Interface
REQ-001 SHALL have parameter DATA_W, default 4: data word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 3: address width; DEPTH = 2**ADDR_W rows.
REQ-003 SHALL have parameter RETAIN, default 60: cycles a row holds data without restore (minimum 4).
REQ-004 SHALL have parameter REF_INT, default 40: auto-refresh interval in cycles (minimum 2).
REQ-005 SHALL have one clock and a synchronous, active-low reset: clk input 1, rising-edge clock; rst_n input 1, synchronous active-low reset.
REQ-006 SHALL have port req_valid input 1: request present.
REQ-007 SHALL have port req_ready output 1: request can be accepted this cycle.
REQ-008 SHALL have port req_we input 1: 1 = write, 0 = read.
REQ-009 SHALL have port req_addr input ADDR_W: row address.
REQ-010 SHALL have port req_wdata input DATA_W: write data.
REQ-011 SHALL have port ref_en input 1: enables the auto-refresh timer.
REQ-012 SHALL have port rsp_valid output 1: one-cycle read-response strobe.
REQ-013 SHALL have port rsp_rdata output DATA_W: read data, valid when rsp_valid = 1.
REQ-014 SHALL have port rsp_err output 1: the read hit a decayed or never-written row; valid when rsp_valid = 1.
REQ-015 SHALL have port ref_busy output 1: a refresh sweep is in progress.

Function
REQ-016 SHALL hold per row a DATA_W data word, a live bit and an age counter of width clog2(RETAIN+1).
REQ-017 SHALL implement FSM states IDLE, ACT, RW and REFRESH.
REQ-018 SHALL drive req_ready = 1 only in IDLE with no refresh pending.
REQ-019 SHALL accept a request on the edge where req_valid and req_ready are both 1.
- Addr, we and wdata are latched on that edge.
- The FSM goes IDLE -> ACT.
REQ-020 SHALL go ACT -> RW unconditionally (row-open cycle) and RW -> IDLE unconditionally.
REQ-021 SHALL, on the RW edge of a write:
- store wdata in the row;
- set live = 1 and age = 0;
- produce no response.
REQ-022 SHALL, on the RW edge of a read:
- register rsp_valid = 1 for exactly one cycle;
- if the row is live: rsp_rdata = row data, rsp_err = 0, and reset the row's age to 0 (restoring read);
- if the row is not live: rsp_rdata = 0, rsp_err = 1.
REQ-023 SHALL make read latency exactly 2 cycles: rsp_valid high in the cycle after the RW edge, i.e. the second cycle after acceptance.
REQ-024 SHALL, every cycle, increment the age of each live row that is not restored that edge.
REQ-025 SHALL, on the edge where a row's incremented age would equal RETAIN, clear live, set age = 0 and force that row's data to 0 (decay).
REQ-026 SHALL, while ref_en = 1, count the refresh timer 0..REF_INT-1 and wrap.
- On the wrap edge, refresh_pending is set.
- A wrap while refresh_pending is already set is dropped (no queueing).
- While ref_en = 0 the timer holds its value; refresh_pending and any sweep in progress are unaffected.
REQ-027 SHALL, in IDLE with refresh_pending set, go to REFRESH; a pending refresh has priority over a simultaneous req_valid.
REQ-028 SHALL, in REFRESH, sweep rows 0..DEPTH-1, one row per cycle, over DEPTH cycles.
- Each live row's age is reset to 0.
- Rows that are not live are untouched.
- On the last row: clear refresh_pending and return to IDLE.
REQ-029 SHALL drive ref_busy = 1 exactly while in REFRESH.
REQ-030 SHALL resolve simultaneous events on the same row as follows:
- a write or restore on the decay edge wins: row is live, age 0;
- a refresh restore on the decay edge wins.
REQ-031 SHALL keep a request presented during ACT, RW or REFRESH pending on the requester side, with no loss and no duplication.

Reset
REQ-032 SHALL, on the edge where rst_n = 0, force:
- FSM to IDLE; timer, refresh_pending and sweep pointer to 0;
- all live bits to 0, all ages to 0, all row data to 0;
- rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, ref_busy = 0, req_ready = 0.
REQ-033 SHALL, on reset mid-operation (ACT, RW or REFRESH), abandon the operation with no array write and no response.
REQ-034 SHALL drive req_ready = 1 in the first cycle after rst_n returns to 1.

Verification
REQ-035 SHALL verify write then read: write addr 3 data 4'hA, then read addr 3 -> rsp_valid exactly 2 cycles after acceptance, rsp_rdata = 4'hA, rsp_err = 0.
REQ-036 SHALL verify decay: ref_en = 0, write addr 5 data 4'h6, idle 60 cycles, read addr 5 -> rsp_rdata = 0, rsp_err = 1.
REQ-037 SHALL verify refresh retention: ref_en = 1, write all 8 rows, idle 300 cycles, read all rows -> all data intact, rsp_err = 0; ref_busy pulses of 8 cycles observed.
REQ-038 SHALL verify refresh priority: req_valid held high when refresh_pending sets in IDLE -> ref_busy for 8 cycles before acceptance; request served exactly once.
REQ-039 SHALL verify restoring read: ref_en = 0, write addr 1, read addr 1 at cycle 50, read again at cycle 100 -> both reads rsp_err = 0.
REQ-040 SHALL verify reset mid-write: assert rst_n = 0 during ACT of a write to addr 2, then read addr 2 -> rsp_err = 1, rsp_rdata = 0.
